// File: rtl/sweep_peak_controller.sv
// sweep_peak_controller
// Steps a mechanism through NUM_POS positions. At each position it waits
// SETTLE_CYCLES clocks, takes an ADC sample, and tracks the maximum sample
// and the position where it occurred. When the sweep completes it publishes
// peak_value/peak_pos and launches the BCD converter.
//
// Optional feature macro: SWEEP_AVG4_EN
//   defined   : four adc_valid samples are summed per position and the
//               compared value is the sum >> 2 (truncated).
//   undefined : one sample per position, no accumulator.
//
// Latency with immediate adc_valid, step_ack and bcd_busy=0, counted in
// rising clock edges from the cycle start is driven to the first cycle
// done is visible (NS = samples per position, 1 or 4):
//   NUM_POS*(SETTLE_CYCLES+NS) + (NUM_POS-1) + 2
module sweep_peak_controller #(
    parameter int NUM_POS       = 16,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] adc_data,
    input  logic        adc_valid,
    output logic        step_req,
    input  logic        step_ack,
    output logic        bcd_start,
    input  logic        bcd_busy,
    output logic [11:0] peak_value,
    output logic [3:0]  peak_pos,
    output logic        busy,
    output logic        done
);

    localparam int          CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [3:0]  LAST_POS    = 4'(NUM_POS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        STEP,
        REPORT
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [3:0]       pos;
    logic [11:0]      run_max;
    logic [3:0]       run_idx;
    logic [CNT_W-1:0] settle_cnt;

    logic             load_start;
    logic             sample_take;
    logic             step_done;
    logic             report_fire;
    logic [11:0]      sample_value;

`ifdef SWEEP_AVG4_EN
    logic [13:0]      avg_acc;
    logic [1:0]       avg_cnt;
    logic [13:0]      avg_sum;

    // Running sum including the sample presented this cycle
    always_comb begin
        avg_sum      = avg_acc + 14'(adc_data);
        sample_value = 12'(avg_sum >> 2);
    end
`else
    // Single-sample mode compares the raw ADC value
    always_comb begin
        sample_value = adc_data;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, control strobes and level outputs
    always_comb begin
        next_state  = state;
        load_start  = 1'b0;
        sample_take = 1'b0;
        step_done   = 1'b0;
        report_fire = 1'b0;
        step_req    = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    next_state = SETTLE;
                end
            end

            SETTLE: begin
                if (settle_cnt == CNT_W'(1)) begin
                    next_state = SAMPLE;
                end
            end

            SAMPLE: begin
                if (adc_valid) begin
`ifdef SWEEP_AVG4_EN
                    if (avg_cnt == 2'd3) begin
                        sample_take = 1'b1;
                    end
`else
                    sample_take = 1'b1;
`endif
                end
                if (sample_take) begin
                    next_state = (pos == LAST_POS) ? REPORT : STEP;
                end
            end

            STEP: begin
                step_req = 1'b1;
                if (step_ack) begin
                    step_done  = 1'b1;
                    next_state = SETTLE;
                end
            end

            REPORT: begin
                if (!bcd_busy) begin
                    report_fire = 1'b1;
                    next_state  = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: position, settle timer, running peak and published result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos        <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            settle_cnt <= '0;
            peak_value <= '0;
            peak_pos   <= '0;
            bcd_start  <= 1'b0;
            done       <= 1'b0;
`ifdef SWEEP_AVG4_EN
            avg_acc    <= '0;
            avg_cnt    <= '0;
`endif
        end else begin
            bcd_start <= 1'b0;
            done      <= 1'b0;

            if (load_start) begin
                pos        <= '0;
                run_max    <= '0;
                run_idx    <= '0;
                settle_cnt <= SETTLE_LOAD;
`ifdef SWEEP_AVG4_EN
                avg_acc    <= '0;
                avg_cnt    <= '0;
`endif
            end

            if (state == SETTLE) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end

`ifdef SWEEP_AVG4_EN
            if (state == SAMPLE && adc_valid) begin
                if (sample_take) begin
                    avg_acc <= '0;
                    avg_cnt <= '0;
                end else begin
                    avg_acc <= avg_sum;
                    avg_cnt <= avg_cnt + 2'd1;
                end
            end
`endif

            // Position 0 always loads; later positions need a strictly larger value
            if (sample_take && (pos == '0 || sample_value > run_max)) begin
                run_max <= sample_value;
                run_idx <= pos;
            end

            if (step_done) begin
                pos        <= pos + 4'd1;
                settle_cnt <= SETTLE_LOAD;
            end

            if (report_fire) begin
                peak_value <= run_max;
                peak_pos   <= run_idx;
                bcd_start  <= 1'b1;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sweep_peak_controller.md
SWEEP_PEAK_CONTROLLER -- requirements
Module: sweep_peak_controller

Interface
REQ-001 Parameter NUM_POS, default 16, number of sweep positions (2..16).
REQ-002 Parameter SETTLE_CYCLES, default 1000, clk cycles to wait after each position change before sampling (>=1).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a sweep.
REQ-006 adc_data  input  12  unsigned ADC sample.
REQ-007 adc_valid  input  1  adc_data valid this cycle.
REQ-008 step_req  output  1  request to advance the mechanism by one position; level signal.
REQ-009 step_ack  input  1  mechanism has completed the requested step.
REQ-010 bcd_start  output  1  single-cycle pulse launching the binary-to-BCD converter on peak_value.
REQ-011 bcd_busy  input  1  BCD converter is mid-conversion.
REQ-012 peak_value  output  12  maximum sample of the last completed sweep.
REQ-013 peak_pos  output  4  position index of peak_value.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  single-cycle pulse at sweep completion.

Function
REQ-016 States: IDLE, SETTLE, SAMPLE, STEP, REPORT; encoding is an implementation choice.
REQ-017 IDLE: start=1 -> clear pos counter and running max/index, load settle counter with SETTLE_CYCLES, go to SETTLE next cycle; start=0 -> stay.
REQ-018 start is ignored in every state other than IDLE.
REQ-019 SETTLE: decrement settle counter each cycle; exit to SAMPLE on the cycle it reaches 0 (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-020 SAMPLE: wait for adc_valid=1; adc_valid outside SAMPLE is ignored.
REQ-021 On accepted sample: if pos==0 or sample > running max, load running max=sample and running index=pos; ties keep the earlier position.
REQ-022 After the accepted sample: pos==NUM_POS-1 -> REPORT; otherwise -> STEP.
REQ-023 STEP: step_req=1 from state entry until the cycle step_ack=1 is seen; that cycle increment pos, reload settle counter, go to SETTLE; step_req=0 the following cycle.
REQ-024 step_ack while not in STEP is ignored; step_req is never asserted outside STEP.
REQ-025 REPORT: while bcd_busy=1 hold; first cycle bcd_busy=0 -> load peak_value/peak_pos from running max/index, pulse bcd_start and done for that one cycle, go to IDLE.
REQ-026 bcd_start is registered so peak_value is stable on the same clock edge bcd_start is asserted and holds until the next REPORT.
REQ-027 peak_value/peak_pos change only in REPORT; an in-progress sweep never disturbs the displayed result.
REQ-028 Total sweep latency with immediate adc_valid/step_ack/bcd_busy=0: deterministic, NUM_POS*(SETTLE_CYCLES+1) + (NUM_POS-1)*1 + 2 cycles start-to-done +/-1; bench checks exact value of the implementation's documented formula.

Reset
REQ-029 Asynchronous reset: state=IDLE, pos=0, running max/index=0, peak_value=0, peak_pos=0, step_req=0, bcd_start=0, done=0, busy=0.
REQ-030 Reset mid-sweep aborts immediately; no done or bcd_start is issued; the next start begins a fresh sweep from pos 0.

Configuration
REQ-031 Macro SWEEP_AVG4_EN defined: SAMPLE accepts four adc_valid samples per position, sums into a 14-bit accumulator, and the compared value is sum>>2 (truncated).
REQ-032 Macro SWEEP_AVG4_EN undefined: one sample per position per REQ-021; no accumulator is built.

Verification
REQ-033 NUM_POS=4, SETTLE_CYCLES=3, samples 100,900,400,900, immediate acks -> peak_value=900, peak_pos=1, one done and one bcd_start pulse, step_req asserted exactly 3 times.
REQ-034 All samples 0 -> peak_value=0, peak_pos=0 (pos 0 loads unconditionally).
REQ-035 step_ack delayed 10 cycles at pos 2 -> step_req held high all 10 cycles, pos unchanged until ack, result unaffected.
REQ-036 bcd_busy=1 for 5 cycles on REPORT entry -> done/bcd_start delayed until bcd_busy=0; start pulsed mid-sweep -> ignored, single done.
REQ-037 reset asserted during SETTLE at pos 2 -> all outputs zero next edge, no done; following sweep with samples 5,6,7,8 -> peak_value=8, peak_pos=3.
REQ-038 With SWEEP_AVG4_EN, pos 0 samples 10,11,12,13 and pos 1 samples 11,11,11,11 -> pos0 value 11, pos1 value 11, tie -> peak_pos=0, peak_value=11.
